// File: rtl/ex_div.sv
// ex_div: iterative 32-bit integer divider for the EX stage.
// Signed and unsigned divide and remainder (DIV/DIVU/REM/REMU). The normal path
// runs a 32-step restoring divide, one quotient bit per cycle. A zero divisor and
// signed overflow (0x80000000 / -1) finish in one cycle without iterating.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start_i     request a divide (only looked at in IDLE)
//   signed_i    1 = two's complement operands
//   rem_i       1 = return remainder, 0 = return quotient
//   dividend_i  dividend, sampled on the accept edge
//   divisor_i   divisor, sampled on the accept edge
//   annul_i     pipeline flush, abandons a divide in progress
//   result_o    registered result, valid while ready_o is high
//   ready_o     one-cycle pulse marking result_o valid
//   stallreq_o  combinational stall request to the pipeline controller
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        rem_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q;
    logic [5:0]  count_q;
    logic [31:0] prem_q;    // partial remainder
    logic [31:0] quo_q;     // dividend bits shift out the top, quotient bits shift in
    logic [31:0] dvsr_q;    // |divisor|
    logic [31:0] result_q;
    logic        sgn_q;
    logic        rem_sel_q;
    logic        dvd_neg_q;
    logic        dvs_neg_q;

    // Operand decode for the accept cycle
    logic        div_zero;
    logic        div_ovf;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;

    always_comb begin
        div_zero = (divisor_i == 32'd0);
        div_ovf  = signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
        dvd_neg  = signed_i && dividend_i[31];
        dvs_neg  = signed_i && divisor_i[31];
        dvd_abs  = dvd_neg ? (32'd0 - dividend_i) : dividend_i;
        dvs_abs  = dvs_neg ? (32'd0 - divisor_i) : divisor_i;
    end

    // One restoring step. The shifted remainder needs 33 bits; after a successful
    // subtract the difference always fits back in 32.
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] fin_quo;
    logic [31:0] fin_rem;

    always_comb begin
        shifted  = {prem_q, quo_q[31]};
        ge       = (shifted >= {1'b0, dvsr_q});
        diff     = shifted[31:0] - dvsr_q;
        step_rem = ge ? diff : shifted[31:0];
        step_quo = {quo_q[30:0], ge};
        // Sign fix-up gives truncation toward zero
        fin_quo  = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? (32'd0 - step_quo) : step_quo;
        fin_rem  = (sgn_q && dvd_neg_q) ? (32'd0 - step_rem) : step_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= 6'd0;
            prem_q    <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            result_q  <= 32'd0;
            sgn_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i && !annul_i) begin
                        if (div_zero) begin
                            result_q <= rem_i ? dividend_i : 32'hFFFF_FFFF;
                            state_q  <= StDone;
                        end else if (div_ovf) begin
                            result_q <= rem_i ? 32'd0 : 32'h8000_0000;
                            state_q  <= StDone;
                        end else begin
                            prem_q    <= 32'd0;
                            quo_q     <= dvd_abs;
                            dvsr_q    <= dvs_abs;
                            sgn_q     <= signed_i;
                            rem_sel_q <= rem_i;
                            dvd_neg_q <= dvd_neg;
                            dvs_neg_q <= dvs_neg;
                            count_q   <= 6'd0;
                            state_q   <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else begin
                        prem_q  <= step_rem;
                        quo_q   <= step_quo;
                        count_q <= count_q + 6'd1;
                        if (count_q == 6'd31) begin
                            result_q <= rem_sel_q ? fin_rem : fin_quo;
                            state_q  <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = !rst && (state_q == StDone) && !annul_i;
    assign stallreq_o = !rst && (((state_q == StIdle) && start_i && !annul_i) ||
                                 (state_q == StRun));

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        rem_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .rem_i      (rem_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = 32'd0;
    bit          mon_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic with the architectural special cases
    function automatic logic [31:0] ref_div(input bit sg, input bit rm,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return rm ? (sa % sb) : (sa / sb);
        end
        return rm ? (a % b) : (a / b);
    endfunction

    function automatic int latency(input bit sg, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ready_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check32("unexpected_ready", {31'd0, ready_o}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check32("result", result_o, e.res);
                    check32("ready_cycle", cyc, e.cyc);
                    last_res = e.res;
                end
            end else begin
                check32("result_hold", result_o, last_res);
            end
        end
    end

    // Starts a divide in the current cycle and returns in the IDLE cycle after DONE.
    // start_i is toggled randomly during RUN and DONE, where it must be ignored.
    task automatic issue(input bit sg, input bit rm, input logic [31:0] a, input logic [31:0] b);
        int   lat;
        exp_t e;
        lat   = latency(sg, a, b);
        e.res = ref_div(sg, rm, a, b);
        e.cyc = cyc + lat;
        sb_q.push_back(e);
        start_i    = 1'b1;
        signed_i   = sg;
        rem_i      = rm;
        dividend_i = a;
        divisor_i  = b;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check32("stallreq", {31'd0, stallreq_o}, (k < lat) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            start_i    = (k < lat) ? 1'($urandom) : 1'b0;
            signed_i   = 1'($urandom);
            rem_i      = 1'($urandom);
            dividend_i = $urandom;
            divisor_i  = $urandom;
        end
    endtask

    // Starts a normal divide and abandons it with annul_i in cycle n (start = cycle 1)
    task automatic issue_annul(input logic [31:0] a, input logic [31:0] b, input int n);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        rem_i      = 1'b0;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (n - 2) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        check32("annul_ready", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        @(negedge clk);
        check32("annul_idle_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Starts a divide and hits it with rst in cycle n (start = cycle 1)
    task automatic issue_reset(input logic [31:0] a, input logic [31:0] b, input int n);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        rem_i      = 1'b0;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (n - 2) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        check32("rst_stall", {31'd0, stallreq_o}, 32'd0);
        check32("rst_ready", {31'd0, ready_o}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        start_i  = 1'b0;
        last_res = 32'd0;
        @(negedge clk);
        check32("rst_result", result_o, 32'd0);
        check32("rst_idle_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          sg;
        int          mode;

        rst        = 1'b1;
        start_i    = 1'b1;
        signed_i   = 1'b1;
        rem_i      = 1'b0;
        annul_i    = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset_stall", {31'd0, stallreq_o}, 32'd0);
        check32("reset_ready", {31'd0, ready_o}, 32'd0);
        check32("reset_result", result_o, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check32("idle_stall", {31'd0, stallreq_o}, 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 1'b0, 32'd100, 32'd7);
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE);
        issue(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
        issue(1'b1, 1'b0, 32'd5, 32'd0);
        issue(1'b1, 1'b1, 32'd5, 32'd0);
        issue(1'b0, 1'b0, 32'd5, 32'd0);
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        issue_annul(32'd1000, 32'd7, 10);
        issue(1'b0, 1'b0, 32'd9, 32'd3);

        // Back-to-back: second start lands in the IDLE cycle right after DONE
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(1'b0, 1'b0, 32'd10, 32'd3);

        issue_reset(32'd12345, 32'd11, 20);
        issue(1'b0, 1'b0, 32'd12345, 32'd11);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'd3);
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            sg   = 1'($urandom);
            a    = $urandom;
            b    = $urandom;
            case (mode)
                0: b = 32'd0;
                1: begin
                    sg = 1'b1;
                    a  = 32'h8000_0000;
                    b  = 32'hFFFF_FFFF;
                end
                2: b = $urandom_range(1, 15);
                3: b = 32'd0 - $urandom_range(1, 15);
                4: a = $urandom_range(0, 100);
                default: ;
            endcase
            issue(sg, 1'($urandom), a, b);
        end

        repeat (3) @(posedge clk);
        check32("queue_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  EX stage requests a divide; sampled only in IDLE.
REQ-005 signed_i  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled with start_i.
REQ-006 rem_i  input  1  1 = return remainder, 0 = return quotient; sampled with start_i.
REQ-007 dividend_i  input  32  dividend; sampled with start_i.
REQ-008 divisor_i  input  32  divisor; sampled with start_i.
REQ-009 annul_i  input  1  pipeline flush; abandons any divide in progress.
REQ-010 result_o  output  32  registered quotient or remainder; valid while ready_o=1.
REQ-011 ready_o  output  1  one-cycle pulse marking result_o valid.
REQ-012 stallreq_o  output  1  combinational stall request to the pipeline controller.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start_i=1, annul_i=0 and divisor_i=0: SHALL go to DONE and load result_o = rem_i ? dividend_i : 32'hFFFFFFFF, regardless of signed_i.
REQ-015 IDLE with start_i=1, annul_i=0, signed_i=1, dividend_i=32'h80000000 and divisor_i=32'hFFFFFFFF: SHALL go to DONE and load result_o = rem_i ? 0 : 32'h80000000.
REQ-016 IDLE with start_i=1 and annul_i=0 otherwise: SHALL capture |dividend| and |divisor| (raw values when signed_i=0), latch signed_i, rem_i and both operand signs, clear the 6-bit count, and go to RUN.
REQ-017 RUN SHALL perform one restoring-division step per cycle: shift the 33-bit partial remainder left by 1, bringing in the next quotient bit; if the result >= divisor, subtract the divisor and set that quotient bit to 1.
REQ-018 RUN SHALL last exactly 32 cycles; on the edge completing step 32 the FSM SHALL go to DONE and load result_o.
REQ-019 Sign fix-up on load: quotient negated when signed and sign(dividend) != sign(divisor); remainder negated when signed and dividend negative. This SHALL give truncation toward zero.
REQ-020 DONE SHALL last exactly one cycle and then return unconditionally to IDLE; start_i SHALL be ignored in DONE.
REQ-021 A new start_i SHALL be accepted in the IDLE cycle immediately following DONE (back-to-back divides).
REQ-022 Timing: when start_i is first presented in cycle 1, ready_o SHALL be high in cycle 34 on the normal path and in cycle 2 on the REQ-014/015 fast paths.
REQ-023 ready_o SHALL equal (state==DONE) & ~annul_i.
REQ-024 stallreq_o SHALL equal (state==IDLE & start_i & ~annul_i) | (state==RUN).
REQ-025 stallreq_o SHALL be low in DONE so the EX instruction advances on that edge.
REQ-026 annul_i=1 in RUN SHALL return the FSM to IDLE on the next edge, with no ready_o pulse and result_o unchanged.
REQ-027 result_o SHALL hold its last loaded value outside DONE.
REQ-028 Operand inputs SHALL NOT be sampled after the accept edge; changes during RUN SHALL have no effect.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL set state=IDLE, count=0, result_o=0 and all internal operand registers to 0.
REQ-030 While rst=1, stallreq_o and ready_o SHALL be 0 regardless of other inputs.
REQ-031 Reset during RUN or DONE SHALL abandon the operation with no ready_o pulse; the first start_i after rst falls SHALL be accepted normally.

Verification
REQ-032 Unsigned 100/7, rem_i=0, then rem_i=1 -> result_o=14, then 2; ready_o in cycle 34; stallreq_o high in cycles 1-33 and low in cycle 34.
REQ-033 Signed -7/2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; signed 7/-2 -> quotient 32'hFFFFFFFD, remainder 1.
REQ-034 5/0 (signed and unsigned) -> quotient 32'hFFFFFFFF, remainder 5, ready_o in cycle 2; signed 32'h80000000/32'hFFFFFFFF -> quotient 32'h80000000, remainder 0, ready_o in cycle 2.
REQ-035 annul_i pulsed in cycle 10 of a divide -> FSM in IDLE at cycle 11, stallreq_o=0, no ready_o; a new 9/3 started in cycle 12 returns 3 in cycle 45.
REQ-036 Back-to-back 0xFFFFFFFF/1 then 10/3 unsigned, second start_i in the cycle after DONE -> results 32'hFFFFFFFF then 3, ready pulses 34 cycles apart.
REQ-037 rst asserted in cycle 20 of a divide -> result_o=0, ready_o never pulses; divide restarted after reset completes correctly.
